// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: shared state encoding and framing constants for the serial single-bit bus.
package serial_bus_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, WDATA, ACK_W, RDATA, DONE} state_t;
    localparam int ADDR_BITS = 16;
    localparam int DATA_BITS = 8;
    localparam int ACK_CYCLES = 4;
    localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/slave_mem.sv
// slave_mem: synchronous single-port DEPTH x 8 register file, 1-cycle read latency.
module slave_mem #(
    parameter int DEPTH = 2048,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wd,
    output logic [7:0]        rd
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic unused_addr;
    assign unused_addr = ^addr;
    always_ff @(posedge clk) begin
        if (we) mem[addr[AW-1:0]] <= wd;
        rd <= mem[addr[AW-1:0]];
    end
endmodule

// File: rtl/serial_slave_port.sv
// serial_slave_port: bus-side slave that deserialises address/write data, acknowledges,
// and serialises read data from a local byte-wide register file.
module serial_slave_port import serial_bus_pkg::*; #(
    parameter int ADDR_W = 12,
    parameter int DEPTH = 2048
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic S_SEL,
    input  logic S_UTIL,
    input  logic S_RW,
    input  logic S_BUS_IN,
    output logic S_BUS_OUT,
    output logic S_ACK,
    output logic S_BSY
);
    state_t state, state_n;
    logic [3:0] count, count_n;
    logic [ADDR_BITS-1:0] addr, addr_n, addr_full;
    logic [DATA_BITS-1:0] wdata, wdata_n, rd_shift, rd_n, rdata;
    logic rw_q, rw_n, out_n, ack_n, we, in_range, unused_addr;

    // Range is judged with the final address bit still on the wire.
    assign addr_full = {S_BUS_IN, addr[ADDR_BITS-2:0]};
    assign in_range = 32'(addr_full[ADDR_W-1:0]) < DEPTH;
    assign unused_addr = ^addr_full;
    assign S_BSY = state != IDLE;

    slave_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk(CLK), .we(we), .addr(addr[ADDR_W-1:0]), .wd(wdata_n), .rd(rdata)
    );

    always_comb begin
        state_n = state;
        count_n = count;
        addr_n = addr;
        wdata_n = wdata;
        rd_n = rd_shift;
        rw_n = rw_q;
        out_n = S_BUS_OUT;
        ack_n = S_ACK;
        we = 1'b0;
        if (!S_SEL) begin
            state_n = IDLE;
            count_n = '0;
            ack_n = 1'b0;
            out_n = 1'b0;
        end else if (S_UTIL) begin
            count_n = count + 4'd1;
            case (state)
                IDLE: begin
                    addr_n[0] = S_BUS_IN;
                    count_n = 4'd1;
                    state_n = ADDR;
                end
                ADDR: begin
                    addr_n[count] = S_BUS_IN;
                    if (count == 4'(ADDR_BITS - 1)) begin
                        rw_n = S_RW;
                        count_n = '0;
                        ack_n = in_range;
                        state_n = in_range ? ACK_A : DONE;
                    end
                end
                ACK_A: if (count == 4'(ACK_CYCLES - 1)) begin
                    count_n = '0;
                    ack_n = 1'b0;
                    state_n = (rw_q == RW_WRITE) ? WDATA : RDATA;
                    if (rw_q != RW_WRITE) begin
                        rd_n = rdata;
                        out_n = rdata[0];
                    end
                end
                WDATA: begin
                    wdata_n[count[2:0]] = S_BUS_IN;
                    if (count == 4'(DATA_BITS - 1)) begin
                        we = 1'b1;
                        count_n = '0;
                        ack_n = 1'b1;
                        state_n = ACK_W;
                    end
                end
                ACK_W: if (count == 4'(ACK_CYCLES - 1)) begin
                    count_n = '0;
                    ack_n = 1'b0;
                    state_n = DONE;
                end
                RDATA: begin
                    rd_n = rd_shift >> 1;
                    out_n = rd_shift[1];
                    if (count == 4'(DATA_BITS - 1)) begin
                        count_n = '0;
                        out_n = 1'b0;
                        state_n = DONE;
                    end
                end
                DONE: count_n = '0;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            count <= '0;
            addr <= '0;
            wdata <= '0;
            rd_shift <= '0;
            rw_q <= 1'b0;
            S_BUS_OUT <= 1'b0;
            S_ACK <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            addr <= addr_n;
            wdata <= wdata_n;
            rd_shift <= rd_n;
            rw_q <= rw_n;
            S_BUS_OUT <= out_n;
            S_ACK <= ack_n;
        end
    end
endmodule

// File: tb/tb_serial_slave_port.sv
// tb_serial_slave_port: directed scenarios for the serial slave with hand-computed expectations.
module tb_serial_slave_port;
    logic CLK = 1'b0, RSTN = 1'b0, S_SEL = 1'b0, S_UTIL = 1'b0, S_RW = 1'b0, S_BUS_IN = 1'b0;
    logic S_BUS_OUT, S_ACK, S_BSY;
    int tests = 0, fails = 0;

    serial_slave_port dut (
        .CLK(CLK), .RSTN(RSTN), .S_SEL(S_SEL), .S_UTIL(S_UTIL), .S_RW(S_RW),
        .S_BUS_IN(S_BUS_IN), .S_BUS_OUT(S_BUS_OUT), .S_ACK(S_ACK), .S_BSY(S_BSY)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input logic s, input logic u, input logic r, input logic d);
        S_SEL = s; S_UTIL = u; S_RW = r; S_BUS_IN = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_addr(input logic [15:0] a, input logic r);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, r, a[i]);
    endtask

    task automatic write_frame(input logic [15:0] a, input logic [7:0] d);
        send_addr(a, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1, d[i]);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_frame(input logic [15:0] a, output logic [7:0] q);
        send_addr(a, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            q[k] = S_BUS_OUT;
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        #2;
        tests++;
        if ({S_ACK, S_BUS_OUT, S_BSY} !== 3'b000) begin
            fails++;
            $display("FAIL reset: ack/out/bsy=%b required 000", {S_ACK, S_BUS_OUT, S_BSY});
        end
        @(posedge CLK);
        #1 RSTN = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_write;
        logic [7:0] d = 8'hA5;
        send_addr(16'h0012, 1'b1);
        tests++;
        if (S_ACK !== 1'b1) begin fails++; $display("FAIL write_addr_ack: %b required 1", S_ACK); end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
            tests++;
            if (S_ACK !== (i < 3)) begin fails++; $display("FAIL write_ack_a[%0d]: %b required %b", i, S_ACK, i < 3); end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b1, d[i]);
            tests++;
            if (S_ACK !== (i == 7)) begin fails++; $display("FAIL write_data_ack[%0d]: %b required %b", i, S_ACK, i == 7); end
        end
        tests++;
        if (dut.u_mem.mem[11'h012] !== 8'hA5) begin
            fails++; $display("FAIL write_mem: %h required a5", dut.u_mem.mem[11'h012]);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
            tests++;
            if (S_ACK !== (i < 3)) begin fails++; $display("FAIL write_ack_w[%0d]: %b required %b", i, S_ACK, i < 3); end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1);
            tests++;
            if ({S_BSY, S_ACK, S_BUS_OUT} !== 3'b100) begin
                fails++; $display("FAIL write_done[%0d]: bsy/ack/out=%b required 100", i, {S_BSY, S_ACK, S_BUS_OUT});
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (S_BSY !== 1'b0) begin fails++; $display("FAIL write_deselect_bsy: %b required 0", S_BSY); end
    endtask

    task automatic test_read(input int pause);
        logic [7:0] b = 8'hA5;
        send_addr(16'h0012, 1'b0);
        tests++;
        if (S_ACK !== 1'b1) begin fails++; $display("FAIL read_addr_ack: %b required 1", S_ACK); end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            tests++;
            if (S_ACK !== (i < 3)) begin fails++; $display("FAIL read_ack[%0d]: %b required %b", i, S_ACK, i < 3); end
        end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (S_BUS_OUT !== b[k]) begin fails++; $display("FAIL read_bit[%0d]: %b required %b", k, S_BUS_OUT, b[k]); end
            if (k == 2) for (int p = 0; p < pause; p++) begin
                cyc(1'b1, 1'b0, 1'b0, 1'b0);
                tests++;
                if (S_BUS_OUT !== 1'b1) begin fails++; $display("FAIL read_pause_hold[%0d]: %b required 1", p, S_BUS_OUT); end
            end
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
        end
        tests++;
        if ({S_BSY, S_BUS_OUT} !== 2'b10) begin fails++; $display("FAIL read_done: bsy/out=%b required 10", {S_BSY, S_BUS_OUT}); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (S_BSY !== 1'b0) begin fails++; $display("FAIL read_deselect_bsy: %b required 0", S_BSY); end
    endtask

    task automatic test_out_of_range;
        logic [7:0] q;
        logic [7:0] d = 8'hFF;
        write_frame(16'h0100, 8'h5A);
        send_addr(16'h0900, 1'b1);
        tests++;
        if ({S_BSY, S_ACK} !== 2'b10) begin fails++; $display("FAIL oor_addr: bsy/ack=%b required 10", {S_BSY, S_ACK}); end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, 1'b1, i < 8 ? d[i] : 1'b0);
            tests++;
            if ({S_ACK, S_BUS_OUT} !== 2'b00) begin
                fails++; $display("FAIL oor_quiet[%0d]: ack/out=%b required 00", i, {S_ACK, S_BUS_OUT});
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        read_frame(16'h0100, q);
        tests++;
        if (q !== 8'h5A) begin fails++; $display("FAIL oor_alias_unchanged: %h required 5a", q); end
    endtask

    task automatic test_abort;
        logic [7:0] q;
        logic [7:0] d = 8'hEE;
        write_frame(16'h0034, 8'h11);
        send_addr(16'h0034, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b1, d[i]);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        tests++;
        if ({S_BSY, S_ACK} !== 2'b00) begin fails++; $display("FAIL abort_idle: bsy/ack=%b required 00", {S_BSY, S_ACK}); end
        write_frame(16'h0001, 8'h3C);
        read_frame(16'h0034, q);
        tests++;
        if (q !== 8'h11) begin fails++; $display("FAIL abort_target: %h required 11", q); end
        read_frame(16'h0001, q);
        tests++;
        if (q !== 8'h3C) begin fails++; $display("FAIL back_to_back_write: %h required 3c", q); end
    endtask

    task automatic test_async_reset;
        logic [7:0] q;
        send_addr(16'h0012, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        #2 RSTN = 1'b0;
        #1;
        tests++;
        if ({S_ACK, S_BSY} !== 2'b00) begin fails++; $display("FAIL async_reset: ack/bsy=%b required 00", {S_ACK, S_BSY}); end
        S_SEL = 1'b0;
        #2 RSTN = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        read_frame(16'h0012, q);
        tests++;
        if (q !== 8'hA5) begin fails++; $display("FAIL post_reset_read: %h required a5", q); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read(0);
        test_read(3);
        test_out_of_range;
        test_abort;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
